// File: rtl/pipeline_sequencer.sv
// Two-stage pipeline control sequencer: start/halt/redirect handling,
// memory-wait stalls with a fault watchdog, and a retired-instruction count.
module pipeline_sequencer #(
   parameter int unsigned WAIT_LIMIT = 15
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic        resume,
   input  logic        redirect,
   input  logic        hlt,
   input  logic        mem_wait,
   output logic        pc_inc_en,
   output logic        ir1_load_en,
   output logic        ir2_load_en,
   output logic        bubble,
   output logic        halted,
   output logic        mem_fault,
   output logic [1:0]  state,
   output logic [15:0] instr_count
);

   typedef enum logic [1:0] {
      IDLE   = 2'b00,
      RUN    = 2'b01,
      FLUSH  = 2'b10,
      HALTED = 2'b11
   } state_t;

   localparam logic [3:0] LIMIT = 4'(WAIT_LIMIT);

   state_t      state_q, state_d;
   logic [3:0]  wait_q, wait_d;
   logic        fault_q, fault_d;
   logic [15:0] count_q, count_d;
   logic        adv;
   logic        bub;

   always_comb begin
      state_d = state_q;
      wait_d  = wait_q;
      fault_d = fault_q;
      count_d = count_q;
      adv     = 1'b0;
      bub     = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (start) state_d = RUN;
         end
         RUN, FLUSH: begin
            if (mem_wait) begin
               // Watchdog trips on the wait cycle after LIMIT stalls.
               if (wait_q == LIMIT) begin
                  fault_d = 1'b1;
                  state_d = HALTED;
               end else begin
                  wait_d = wait_q + 4'd1;
               end
            end else begin
               adv = 1'b1;
               if (state_q == FLUSH) begin
                  bub     = 1'b1;
                  state_d = RUN;
               end else if (hlt) begin
                  state_d = HALTED;
               end else if (redirect) begin
                  state_d = FLUSH;
               end
            end
         end
         HALTED: begin
            if (resume && !fault_q) state_d = RUN;
         end
      endcase
      if (!mem_wait || state_d != state_q) wait_d = 4'd0;
      if (adv && !bub) count_d = count_q + 16'd1;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         wait_q  <= 4'd0;
         fault_q <= 1'b0;
         count_q <= 16'd0;
      end else begin
         state_q <= state_d;
         wait_q  <= wait_d;
         fault_q <= fault_d;
         count_q <= count_d;
      end
   end

   assign pc_inc_en   = adv;
   assign ir1_load_en = adv;
   assign ir2_load_en = adv;
   assign bubble      = bub;
   assign halted      = (state_q == HALTED);
   assign mem_fault   = fault_q;
   assign state       = state_q;
   assign instr_count = count_q;

endmodule

// File: tb/tb_pipeline_sequencer.sv
// Directed bench for pipeline_sequencer with a cycle-level reference model
// compared against the outputs on every falling edge.
module tb_pipeline_sequencer;

   localparam int unsigned WL = 15;

   logic        clk = 1'b0;
   logic        rst;
   logic        start, resume, redirect, hlt, mem_wait;
   logic        pc_inc_en, ir1_load_en, ir2_load_en, bubble;
   logic        halted, mem_fault;
   logic [1:0]  state;
   logic [15:0] instr_count;

   int n_chk  = 0;
   int n_fail = 0;

   pipeline_sequencer #(.WAIT_LIMIT(WL)) dut (
      .clk        (clk),
      .rst        (rst),
      .start      (start),
      .resume     (resume),
      .redirect   (redirect),
      .hlt        (hlt),
      .mem_wait   (mem_wait),
      .pc_inc_en  (pc_inc_en),
      .ir1_load_en(ir1_load_en),
      .ir2_load_en(ir2_load_en),
      .bubble     (bubble),
      .halted     (halted),
      .mem_fault  (mem_fault),
      .state      (state),
      .instr_count(instr_count)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp,
                  $time);
      end
   endtask

   // Reference model: named phase, stall streak length, retire total.
   int m_st;
   int m_streak;
   bit m_fault;
   int m_cnt;

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_st = 0; m_streak = 0; m_fault = 0; m_cnt = 0;
      end else if ((m_st == 1 || m_st == 2) && mem_wait) begin
         if (m_streak >= WL) begin
            m_fault = 1; m_st = 3; m_streak = 0;
         end else begin
            m_streak = m_streak + 1;
         end
      end else begin
         m_streak = 0;
         if (m_st == 1) begin
            m_cnt = (m_cnt + 1) % 65536;
            if (hlt) m_st = 3;
            else if (redirect) m_st = 2;
         end else if (m_st == 2) begin
            m_st = 1;
         end else if (m_st == 0) begin
            if (start) m_st = 1;
         end else if (resume && !m_fault) begin
            m_st = 1;
         end
      end
   end

   bit chk_en = 0;

   always @(negedge clk) begin
      if (chk_en) begin
         bit go;
         go = (m_st == 1 || m_st == 2) && !mem_wait;
         chk("state", 32'(state), 32'(m_st));
         chk("pc_inc_en", 32'(pc_inc_en), 32'(go));
         chk("ir1_load_en", 32'(ir1_load_en), 32'(go));
         chk("ir2_load_en", 32'(ir2_load_en), 32'(go));
         chk("bubble", 32'(bubble), 32'(go && m_st == 2));
         chk("halted", 32'(halted), 32'(m_st == 3));
         chk("mem_fault", 32'(mem_fault), 32'(m_fault));
         chk("instr_count", 32'(instr_count), 32'(m_cnt));
      end
   end

   task automatic tick(input int n = 1);
      repeat (n) begin
         @(posedge clk);
         #2;
      end
   endtask

   initial begin
      rst = 1; start = 0; resume = 0; redirect = 0; hlt = 0; mem_wait = 0;
      tick(2);
      chk("rst_state", 32'(state), 32'd0);
      chk("rst_count", 32'(instr_count), 32'd0);
      chk("rst_en", 32'({pc_inc_en, ir1_load_en, ir2_load_en, bubble}), 32'd0);
      rst = 0;
      chk_en = 1;
      tick(3);
      chk("idle_hold", 32'(state), 32'd0);

      start = 1; tick(); start = 0;
      tick(10);
      chk("run10_count", 32'(instr_count), 32'd10);
      chk("run10_state", 32'(state), 32'd1);

      redirect = 1; tick(); redirect = 0;
      chk("flush_state", 32'(state), 32'd2);
      chk("flush_bubble", 32'(bubble), 32'd1);
      tick(2);
      chk("redirect_count", 32'(instr_count), 32'd12);

      mem_wait = 1;
      #1 chk("wait_en", 32'({pc_inc_en, ir1_load_en, ir2_load_en}), 32'd0);
      tick(3); mem_wait = 0;
      chk("wait3_count", 32'(instr_count), 32'd12);
      chk("wait3_fault", 32'(mem_fault), 32'd0);
      tick();
      chk("wait3_resume", 32'(instr_count), 32'd13);

      redirect = 1; tick(); redirect = 0;
      mem_wait = 1; hlt = 1; tick();
      chk("flush_wait_hold", 32'(state), 32'd2);
      mem_wait = 0; tick(); hlt = 0;
      chk("flush_ignores_hlt", 32'(state), 32'd1);
      chk("flush_count", 32'(instr_count), 32'd14);

      hlt = 1; redirect = 1; tick(); hlt = 0; redirect = 0;
      chk("hlt_state", 32'(state), 32'd3);
      chk("hlt_bubble", 32'(bubble), 32'd0);
      chk("hlt_count", 32'(instr_count), 32'd15);
      start = 1; tick(); start = 0;
      chk("halt_ign_start", 32'(state), 32'd3);
      resume = 1; tick(); resume = 0;
      chk("resume_run", 32'(state), 32'd1);

      mem_wait = 1; tick(15);
      chk("wait15_state", 32'(state), 32'd1);
      chk("wait15_fault", 32'(mem_fault), 32'd0);
      tick(); mem_wait = 0;
      chk("wait16_state", 32'(state), 32'd3);
      chk("wait16_fault", 32'(mem_fault), 32'd1);
      resume = 1; tick(); resume = 0;
      chk("fault_ign_resume", 32'(state), 32'd3);
      rst = 1;
      #1 chk("rst_fault", 32'(mem_fault), 32'd0);
      chk("rst_halted", 32'(halted), 32'd0);
      tick(); rst = 0;

      start = 1; tick(); start = 0;
      redirect = 1; tick(); redirect = 0;
      #1 chk("pre_rst_bubble", 32'(bubble), 32'd1);
      rst = 1;
      #1 chk("async_state", 32'(state), 32'd0);
      chk("async_out",
          32'({pc_inc_en, ir1_load_en, ir2_load_en, bubble, halted}), 32'd0);
      chk("async_count", 32'(instr_count), 32'd0);
      tick(); rst = 0;

      start = 1; tick(); start = 0;
      tick(65535);
      chk("count_ffff", 32'(instr_count), 32'h0000FFFF);
      tick();
      chk("count_wrap", 32'(instr_count), 32'd0);

      chk_en = 0;
      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule
